// File: rtl/cic_pkg.sv
// Shared sizing and arithmetic helpers for the parametrised CIC interpolator.
// Helpers work on 64-bit signed values, so the internal width must stay below 64 bits.
package cic_pkg;

   function automatic int cic_width(input int in_w, input int n, input int rmax_log2);
      return in_w + n * rmax_log2;
   endfunction

   function automatic int rs_width(input int rmax_log2);
      return $clog2(rmax_log2 + 1);
   endfunction

   // Arithmetic right shift by s with round-half-up.
   function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                        input int s);
      logic signed [63:0] half;
      half = (s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0;
      return (v + half) >>> s;
   endfunction

   // Clip v into the signed out_w range and report whether clipping occurred.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int out_w,
                                                   output logic clipped);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      clipped = 1'b0;
      if (v > hi) begin
         clipped = 1'b1;
         return hi;
      end
      if (v < lo) begin
         clipped = 1'b1;
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/cic_int_stage.sv
// One modular-width CIC integrator: enabled accumulator with synchronous clear.
module cic_int_stage #(
   parameter int W = 28
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic [W-1:0] acc
);

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (en) begin
         if (clr) acc <= '0;
         else     acc <= acc + din;
      end
   end

endmodule

// File: rtl/cic_interp_param.sv
// Parametrised CIC interpolator with runtime power-of-two rate, gain normalisation,
// rounding and saturation; downstream strobes clk_enable, ce_out pulls the next input.
module cic_interp_param
   import cic_pkg::*;
#(
   parameter  int IN_W          = 16,
   parameter  int OUT_W         = 16,
   parameter  int N             = 3,
   parameter  int RMAX_LOG2     = 4,
   parameter  int RATE_RST_LOG2 = 2,
   localparam int W             = cic_width(IN_W, N, RMAX_LOG2),
   localparam int RS_W          = rs_width(RMAX_LOG2)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic [RS_W-1:0]  rate_log2,
   input  logic [IN_W-1:0]  filter_in,
   output logic [OUT_W-1:0] filter_out,
   output logic             ce_out,
   output logic             sat_flag
);

   localparam logic [RS_W-1:0] RMAX_SEL = RS_W'(RMAX_LOG2);
   localparam logic [RS_W-1:0] RATE_RST = RS_W'(RATE_RST_LOG2);
   localparam int              NM1      = N - 1;

   logic [RS_W-1:0]      rate_act;
   logic [RS_W-1:0]      rate_req;
   logic [RMAX_LOG2-1:0] phase;
   logic [RMAX_LOG2-1:0] phase_max;
   logic                 ce;
   logic                 flush;

   logic [N:1][W-1:0]    d;
   logic [N:0][W-1:0]    c;
   logic [W-1:0]         stuff;
   logic [W-1:0]         integ [1:N];

   logic signed [63:0]   i_n_ext;
   logic signed [63:0]   y_round;
   logic [OUT_W-1:0]     out_next;
   logic                 clipped;
   int                   shift;

   assign rate_req  = (rate_log2 > RMAX_SEL) ? RMAX_SEL : rate_log2;
   assign phase_max = RMAX_LOG2'((32'd1 << rate_act) - 32'd1);
   assign ce        = clk_enable & (phase == '0) & ~reset;
   assign flush     = ce & (rate_req != rate_act);
   assign ce_out    = ce;

   // A rate change flushes the pipeline and restarts the phase at the new ratio.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rate_act <= RATE_RST;
         phase    <= '0;
      end else if (flush) begin
         rate_act <= rate_req;
         phase    <= '0;
      end else if (clk_enable) begin
         phase <= (phase == phase_max) ? '0 : phase + 1'b1;
      end
   end

   // NOTE: every variable written here gets a value on every pass, so no latch is inferred.
   always_comb begin
      c[0] = {{(W - IN_W){filter_in[IN_W-1]}}, filter_in};
      for (int k = 1; k <= N; k++) begin
         c[k] = c[k-1] - d[k];
      end
   end

   // NOTE: the comb delays are few enough to live in flops, so they take the async reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d <= '0;
      end else if (flush) begin
         d <= '0;
      end else if (ce) begin
         for (int k = 1; k <= N; k++) begin
            d[k] <= c[k-1];
         end
      end
   end

   assign stuff = (phase == '0) ? c[N] : '0;

   for (genvar k = 1; k <= N; k++) begin : g_int
      if (k == 1) begin : g_first
         cic_int_stage #(.W(W)) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (clk_enable),
            .clr   (flush),
            .din   (stuff),
            .acc   (integ[k])
         );
      end else begin : g_rest
         cic_int_stage #(.W(W)) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (clk_enable),
            .clr   (flush),
            .din   (integ[k-1]),
            .acc   (integ[k])
         );
      end
   end

   // The integrator gain is R**(N-1); shifting by (N-1)*rate_act restores unity DC gain.
   assign i_n_ext = {{(64 - W){integ[N][W-1]}}, integ[N]};
   assign shift   = NM1 * int'(rate_act);

   always_comb begin
      y_round  = round_half_up(i_n_ext, shift);
      out_next = OUT_W'(saturate(y_round, OUT_W, clipped));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filter_out <= '0;
         sat_flag   <= 1'b0;
      end else if (flush) begin
         filter_out <= '0;
      end else if (clk_enable) begin
         filter_out <= out_next;
         if (clipped) sat_flag <= 1'b1;
      end
   end

endmodule
